// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths and types for the two-port RAM arbiter.
package ram_arb_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;
  typedef logic req_id_t;
  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    err;
  } rd_ent_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; the pointer moves only when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  // ptr_q = 1 favours requester 1 on contention
  always_comb begin
    gnt   = !rst_n ? 2'b00 : (&req) ? (ptr_q ? 2'b10 : 2'b01) : req;
    ptr_d = (|gnt) ? gnt[0] : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one registered single-port RAM between two requesters,
// returning read data two cycles after acceptance; word 0 is unimplemented.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_wr,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_gnt,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_rerr,
  input  logic          req1_valid,
  input  logic          req1_wr,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_gnt,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_rerr,
  output logic [AW-1:0] mem_add,
  output logic          mem_wr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);
  logic [1:0]    gnt;
  logic          acc;
  req_id_t       sel;
  logic          c_wr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [AW-1:0] mem_add_q, mem_add_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] mem_data_in_q, mem_data_in_d;
  rd_ent_t       s1_q, s1_d, s2_q, s2_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  always_comb begin
    acc           = |gnt;
    sel           = gnt[1];
    c_wr          = sel ? req1_wr : req0_wr;
    c_addr        = sel ? req1_addr : req0_addr;
    c_wdata       = sel ? req1_wdata : req0_wdata;
    mem_add_d     = acc ? c_addr : mem_add_q;
    mem_data_in_d = acc ? c_wdata : mem_data_in_q;
    mem_wr_d      = acc & c_wr & (c_addr != '0);
    s1_d.valid    = acc & ~c_wr;
    s1_d.id       = sel;
    s1_d.err      = c_addr == '0;
    s2_d          = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_add_q     <= '0;
      mem_wr_q      <= 1'b0;
      mem_data_in_q <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
    end else begin
      mem_add_q     <= mem_add_d;
      mem_wr_q      <= mem_wr_d;
      mem_data_in_q <= mem_data_in_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
    end

  // stage 2 lines up with the RAM's registered read data
  assign req0_gnt    = gnt[0];
  assign req1_gnt    = gnt[1];
  assign req0_rvalid = s2_q.valid & (s2_q.id == 1'b0);
  assign req1_rvalid = s2_q.valid & (s2_q.id == 1'b1);
  assign req0_rerr   = req0_rvalid & s2_q.err;
  assign req1_rerr   = req1_rvalid & s2_q.err;
  assign req0_rdata  = (req0_rvalid & ~s2_q.err) ? mem_data_out : '0;
  assign req1_rdata  = (req1_rvalid & ~s2_q.err) ? mem_data_out : '0;
  assign mem_add     = mem_add_q;
  assign mem_wr      = mem_wr_q;
  assign mem_data_in = mem_data_in_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a registered RAM model.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0v, r0w, r1v, r1w;
  logic [AW-1:0] r0a, r1a;
  logic [DW-1:0] r0d, r1d;
  logic          g0, g1, rv0, rv1, re0, re1, mem_wr;
  logic [DW-1:0] rd0, rd1, mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] ram [1<<AW];
  int checks = 0;
  int failures = 0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_wr(r0w), .req0_addr(r0a), .req0_wdata(r0d),
    .req0_gnt(g0), .req0_rvalid(rv0), .req0_rdata(rd0), .req0_rerr(re0),
    .req1_valid(r1v), .req1_wr(r1w), .req1_addr(r1a), .req1_wdata(r1d),
    .req1_gnt(g1), .req1_rvalid(rv1), .req1_rdata(rd1), .req1_rerr(re1),
    .mem_add(mem_add), .mem_wr(mem_wr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_add] <= mem_data_in;
    mem_data_out <= ram[mem_add];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmd0(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0v = v; r0w = w; r0a = a; r0d = d;
  endtask

  task automatic cmd1(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1v = v; r1w = w; r1a = a; r1d = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i * 3 + 1);
    cmd0(1, 0, 10, 0);
    cmd1(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_gnt0", g0, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_add", mem_add, 0);
    chk("rst_mem_din", mem_data_in, 0);
    chk("rst_rvalid", {rv0, rv1, re0, re1}, 0);
    step;
    rst_n = 1'b1;
    // alternating contention right after reset
    cmd0(1, 0, 10, 0); cmd1(1, 0, 11, 0);
    @(negedge clk); chk("rr_c0_gnt", {g1, g0}, 2'b01); step;
    cmd0(1, 0, 12, 0);
    @(negedge clk); chk("rr_c1_gnt", {g1, g0}, 2'b10); step;
    cmd1(1, 0, 13, 0);
    @(negedge clk); chk("rr_c2_gnt", {g1, g0}, 2'b01);
    chk("rr_c2_rv", {rv1, rv0}, 2'b01); chk("rr_c2_rd0", rd0, 8'h1F); step;
    cmd0(1, 0, 14, 0);
    @(negedge clk); chk("rr_c3_gnt", {g1, g0}, 2'b10);
    chk("rr_c3_rv", {rv1, rv0}, 2'b10); chk("rr_c3_rd1", rd1, 8'h22); chk("rr_c3_rd0_zero", rd0, 0); step;
    cmd1(0, 0, 0, 0);
    @(negedge clk); chk("rr_c4_gnt", {g1, g0}, 2'b01);
    chk("rr_c4_rv", {rv1, rv0}, 2'b01); chk("rr_c4_rd0", rd0, 8'h25); step;
    cmd0(0, 0, 0, 0);
    @(negedge clk); chk("rr_c5_rv", {rv1, rv0}, 2'b10); chk("rr_c5_rd1", rd1, 8'h28); step;
    @(negedge clk); chk("rr_c6_rv", {rv1, rv0}, 2'b01); chk("rr_c6_rd0", rd0, 8'h2B); step;
    @(negedge clk); chk("rr_c7_rv", {rv1, rv0}, 2'b00); chk("rr_c7_rd0", rd0, 0); step;
    // solo grant moves the pointer
    cmd1(1, 0, 21, 0);
    @(negedge clk); chk("solo1_gnt", {g1, g0}, 2'b10); step;
    cmd0(1, 0, 20, 0); cmd1(1, 0, 22, 0);
    @(negedge clk); chk("solo1_next_gnt", {g1, g0}, 2'b01); step;
    cmd0(0, 0, 0, 0);
    @(negedge clk); chk("solo1_last_gnt", {g1, g0}, 2'b10); step;
    cmd1(0, 0, 0, 0);
    step; step; step;
    // write then read addr 5
    cmd0(1, 1, 5, 8'hA5);
    @(negedge clk); chk("raw_wr_gnt", g0, 1); step;
    cmd0(1, 0, 5, 0);
    @(negedge clk); chk("raw_mem_wr", mem_wr, 1); chk("raw_mem_add", mem_add, 5);
    chk("raw_mem_din", mem_data_in, 8'hA5); chk("raw_rd_gnt", g0, 1); step;
    cmd0(0, 0, 0, 0);
    @(negedge clk); chk("raw_t2_mem_wr", mem_wr, 0); chk("raw_t2_rv", {rv1, rv0}, 0); step;
    @(negedge clk); chk("raw_rv0", rv0, 1); chk("raw_rd0", rd0, 8'hA5);
    chk("raw_rerr", re0, 0); chk("raw_rd1_zero", rd1, 0); step;
    // unimplemented word 0
    cmd0(1, 1, 0, 8'hFF);
    @(negedge clk); chk("a0_wr_gnt", g0, 1); step;
    cmd0(1, 0, 0, 0);
    @(negedge clk); chk("a0_mem_wr", mem_wr, 0); chk("a0_mem_add", mem_add, 0); step;
    cmd0(0, 0, 0, 0);
    step;
    @(negedge clk); chk("a0_rv0", rv0, 1); chk("a0_rerr", re0, 1); chk("a0_rd0", rd0, 0); step;
    // top address, no wrap
    cmd1(1, 1, 1023, 8'h3C);
    @(negedge clk); chk("top_wr_gnt", g1, 1); step;
    cmd1(0, 0, 0, 0); cmd0(1, 0, 1023, 0);
    @(negedge clk); chk("top_rd_gnt", g0, 1); chk("top_mem_wr", mem_wr, 1);
    chk("top_mem_add", mem_add, 10'h3FF); chk("top_mem_din", mem_data_in, 8'h3C); step;
    cmd0(0, 0, 0, 0);
    @(negedge clk); chk("top_t2_mem_wr", mem_wr, 0); step;
    @(negedge clk); chk("top_rv0", rv0, 1); chk("top_rd0", rd0, 8'h3C);
    chk("top_rerr", re0, 0); chk("top_hold_add", mem_add, 10'h3FF); step;
    // reset while a read is in flight
    cmd0(1, 0, 5, 0);
    @(negedge clk); chk("inrst_gnt", g0, 1); step;
    rst_n = 1'b0;
    @(negedge clk); chk("inrst_gnt_low", g0, 0); chk("inrst_mem_add", mem_add, 0);
    chk("inrst_mem_wr", mem_wr, 0); chk("inrst_mem_din", mem_data_in, 0);
    chk("inrst_rv", {rv1, rv0, re1, re0}, 0); step;
    rst_n = 1'b1;
    cmd0(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk($sformatf("post_rst_rv%0d", i), {rv1, rv0, re1, re0}, 0); step;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
